// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: serial-configured FCW sequencer for the NCO phase accumulator.
// Define NCO_SWEEP_EN to build in STEP/LEN, the frame counter and the chirp/repeat logic.
module nco_sweep_ctrl #(
  parameter int FCW_W = 20,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CfgEn,
  input  logic             CfgIn,
  input  logic             Vld,
  output logic             En,
  output logic [FCW_W-1:0] FCW,
  output logic             Busy,
  output logic             Done,
  output logic             CfgErr,
  output logic [1:0]       dbg_state_o
);

  localparam int FRAME_W = 24;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Serial front-end
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic               cfg_err_q, cfg_err_d;
  logic               frame_ok;
  logic [3:0]         cfg_addr;
  logic [19:0]        cfg_data;

  // Register file
  logic [FCW_W-1:0]   base_q, base_d;
  logic               run_q, run_d;
`ifdef NCO_SWEEP_EN
  logic [FCW_W-1:0]   step_q, step_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               sweep_q, sweep_d;
  logic               rep_q, rep_d;
  logic [LEN_W-1:0]   frm_cnt_q, frm_cnt_d;
  logic               reload_q, reload_d;
`else
  logic               unused_len_w;
  assign unused_len_w = (LEN_W > 0);
`endif

  // Sequencer
  state_e             state_q, state_d;
  logic               en_q, en_d;
  logic [FCW_W-1:0]   fcw_q, fcw_d;

  assign cfg_addr = sr_q[23:20];
  assign cfg_data = sr_q[19:0];

  // A frame closes on the first low CfgEn edge after any high window (count != 0).
  always_comb begin
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    cfg_err_d = cfg_err_q;
    frame_ok  = 1'b0;
    if (CfgEn) begin
      sr_d = {sr_q[FRAME_W-2:0], CfgIn};
      if (bit_cnt_q != 5'd25) bit_cnt_d = bit_cnt_q + 5'd1;
    end else if (bit_cnt_q != 5'd0) begin
      bit_cnt_d = 5'd0;
      if (bit_cnt_q == 5'd24) frame_ok = 1'b1;
      else                    cfg_err_d = 1'b1;
    end
    if (frame_ok && (cfg_addr == 4'd3)) cfg_err_d = 1'b0;
  end

  always_comb begin
    base_d  = base_q;
    run_d   = run_q;
`ifdef NCO_SWEEP_EN
    step_d  = step_q;
    len_d   = len_q;
    sweep_d = sweep_q;
    rep_d   = rep_q;
`endif
    if (frame_ok) begin
      case (cfg_addr)
        4'd0: base_d = cfg_data[FCW_W-1:0];
`ifdef NCO_SWEEP_EN
        4'd1: step_d = cfg_data[FCW_W-1:0];
        4'd2: len_d  = cfg_data[LEN_W-1:0];
        4'd3: begin
          run_d   = cfg_data[0];
          sweep_d = cfg_data[1];
          rep_d   = cfg_data[2];
        end
`else
        4'd3: run_d = cfg_data[0];
`endif
        default: ;
      endcase
    end
  end

  // Vld is a one-cycle strobe from the accumulator; FCW only moves on edges where it is high.
  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    fcw_d     = fcw_q;
`ifdef NCO_SWEEP_EN
    frm_cnt_d = frm_cnt_q;
    reload_d  = reload_q;
`endif
    case (state_q)
      S_IDLE: begin
        en_d = 1'b0;
        if (run_q) state_d = S_ARM;
      end
      S_ARM: begin
        if (!run_q) begin
          state_d = S_IDLE;
          en_d    = 1'b0;
        end else begin
          fcw_d   = base_q;
          en_d    = 1'b1;
          state_d = S_RUN;
`ifdef NCO_SWEEP_EN
          frm_cnt_d = len_q;
          reload_d  = 1'b0;
`endif
        end
      end
      S_RUN: begin
        if (!run_q) begin
          state_d = S_IDLE;
          en_d    = 1'b0;
        end else if (Vld) begin
`ifdef NCO_SWEEP_EN
          if (!sweep_q) begin
            fcw_d    = base_q;
            reload_d = 1'b0;
          end else if (reload_q) begin
            // The last stepped value has had its frame; restart the ramp.
            fcw_d     = base_q;
            frm_cnt_d = len_q;
            reload_d  = 1'b0;
          end else begin
            fcw_d = fcw_q + step_q;
            if (frm_cnt_q == LEN_W'(1)) begin
              if (rep_q) reload_d = 1'b1;
              else       state_d  = S_DONE;
            end
            if (frm_cnt_q != '0) frm_cnt_d = frm_cnt_q - LEN_W'(1);
          end
`else
          fcw_d = base_q;
`endif
        end
      end
      S_DONE: begin
        if (!run_q) begin
          state_d = S_IDLE;
          en_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
      cfg_err_q <= 1'b0;
      base_q    <= '0;
      run_q     <= 1'b0;
      state_q   <= S_IDLE;
      en_q      <= 1'b0;
      fcw_q     <= '0;
`ifdef NCO_SWEEP_EN
      step_q    <= '0;
      len_q     <= '0;
      sweep_q   <= 1'b0;
      rep_q     <= 1'b0;
      frm_cnt_q <= '0;
      reload_q  <= 1'b0;
`endif
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      cfg_err_q <= cfg_err_d;
      base_q    <= base_d;
      run_q     <= run_d;
      state_q   <= state_d;
      en_q      <= en_d;
      fcw_q     <= fcw_d;
`ifdef NCO_SWEEP_EN
      step_q    <= step_d;
      len_q     <= len_d;
      sweep_q   <= sweep_d;
      rep_q     <= rep_d;
      frm_cnt_q <= frm_cnt_d;
      reload_q  <= reload_d;
`endif
    end
  end

  assign En          = en_q;
  assign FCW         = fcw_q;
  assign Busy        = (state_q == S_ARM) || (state_q == S_RUN);
`ifdef NCO_SWEEP_EN
  assign Done        = (state_q == S_DONE);
`else
  assign Done        = 1'b0;
`endif
  assign CfgErr      = cfg_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: serial config table, timed start/stop sequences and
// random static/sweep runs checked against a frame-index model of the FCW sequence.
module tb_nco_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        CfgEn;
  logic        CfgIn;
  logic        Vld;
  logic        En;
  logic [19:0] FCW;
  logic        Busy;
  logic        Done;
  logic        CfgErr;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  logic [19:0] exp_q[$];

  nco_sweep_ctrl #(.FCW_W(20), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .CfgEn(CfgEn), .CfgIn(CfgIn), .Vld(Vld),
    .En(En), .FCW(FCW), .Busy(Busy), .Done(Done), .CfgErr(CfgErr),
    .dbg_state_o(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // accumulator stand-in: first strobe one cycle after En rises, then every 7 cycles
  initial begin : vld_gen
    int phase;
    phase = 0;
    Vld = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!En) begin
        Vld   = 1'b0;
        phase = 0;
      end else begin
        Vld   = (phase == 0);
        phase = (phase == 6) ? 0 : phase + 1;
      end
    end
  end

  // reference model: FCW as a function of frames elapsed since the run started
  logic [19:0] m_base, m_step, m_cur;
  int          m_len, m_k;
  bit          m_sweep, m_rep, chk_on, vld_s;

  function automatic logic [19:0] model_fcw(input int k);
`ifdef NCO_SWEEP_EN
    logic [31:0] t;
    int kk;
    if (!m_sweep) return m_base;
    kk = k;
    if (m_len != 0) kk = m_rep ? (k % (m_len + 1)) : ((k > m_len) ? m_len : k);
    t = 32'(m_base) + 32'(m_step) * 32'(kk);
    return t[19:0];
`else
    if (k < 0) return 20'h0;
    return m_base;
`endif
  endfunction

  function automatic logic model_done(input int k);
`ifdef NCO_SWEEP_EN
    return m_sweep && !m_rep && (m_len != 0) && (k >= m_len);
`else
    if (k < 0) return 1'b1;
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: one clock, sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    vld_s = Vld;
    #1;
    if (chk_on) begin
      if (vld_s) begin
        m_k++;
        m_cur = model_fcw(m_k);
      end
      check("run_fcw", FCW, m_cur);
      check("run_done", Done, model_done(m_k));
      check("run_busy", Busy, !model_done(m_k));
      check("run_en", En, 1);
    end
  endtask

  task automatic wait_vld();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!vld_s && n < 20);
    if (!vld_s) begin
      total++;
      bad++;
      $display("FAIL vld_timeout: got no strobe want strobe within 20 cycles");
    end
  endtask

  task automatic send_frame(input logic [3:0] addr, input logic [19:0] data, input int nbits);
    logic [24:0] w;
    w = {addr, data, 1'b0};
    CfgEn = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      CfgIn = w[24-i];
      tick();
    end
    CfgEn = 1'b0;
    CfgIn = 1'b0;
    tick();
  endtask

  task automatic write_reg(input logic [3:0] addr, input logic [19:0] data);
    send_frame(addr, data, 24);
    case (addr)
      4'd0: m_base = data;
      4'd1: m_step = data;
      4'd2: m_len  = int'(data[15:0]);
      default: ;
    endcase
  endtask

  task automatic start_run(input logic [19:0] ctrl);
    chk_on = 1'b0;
    send_frame(4'd3, ctrl, 24);
    m_sweep = ctrl[1];
    m_rep   = ctrl[2];
    m_k     = 0;
    check("start_en_at_commit", En, 0);
    tick();
    check("arm_busy", Busy, 1);
    check("arm_en", En, 0);
    tick();
    check("run_en_rise", En, 1);
    check("run_fcw_base", FCW, m_base);
    check("run_busy_rise", Busy, 1);
    check("run_done_low", Done, 0);
    m_cur  = m_base;
    chk_on = 1'b1;
  endtask

  task automatic stop_run();
    chk_on = 1'b0;
    send_frame(4'd3, 20'h0, 24);
    check("stop_en_at_commit", En, 1);
    tick();
    check("stop_en", En, 0);
    check("stop_busy", Busy, 0);
    check("stop_done", Done, 0);
  endtask

  typedef struct {
    logic [3:0]  addr;
    logic [19:0] data;
    int          nbits;
    bit          exp_err;
  } cfg_vec_t;

  cfg_vec_t vecs [6];

  initial begin
    rst = 1'b1; CfgEn = 1'b0; CfgIn = 1'b0; chk_on = 1'b0;
    m_base = '0; m_step = '0; m_len = 0; m_sweep = 1'b0; m_rep = 1'b0; m_k = 0; m_cur = '0;

    vecs[0] = '{4'h0, 20'h01000, 24, 1'b0};
    vecs[1] = '{4'h0, 20'h0ABCD, 23, 1'b1};
    vecs[2] = '{4'h0, 20'h0ABCD, 25, 1'b1};
    vecs[3] = '{4'h5, 20'h12345, 24, 1'b1};
    vecs[4] = '{4'h2, 20'h00000, 24, 1'b1};
    vecs[5] = '{4'h3, 20'h00000, 24, 1'b0};

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_en", En, 0);
    check("rst_fcw", FCW, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_cfgerr", CfgErr, 0);

    // serial frame table while idle
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].addr, vecs[i].data, vecs[i].nbits);
      if (vecs[i].nbits == 24 && vecs[i].addr == 4'h0) m_base = vecs[i].data;
      check($sformatf("cfg_err_v%0d", i), CfgErr, vecs[i].exp_err);
      check($sformatf("cfg_busy_v%0d", i), Busy, 0);
      check($sformatf("cfg_fcw_v%0d", i), FCW, 0);
    end

    // static run, then BASE change mid-frame
    start_run(20'h1);
    wait_vld();
    wait_vld();
    write_reg(4'd0, 20'h02000);
    check("base_hold_before_vld", FCW, 20'h01000);
    exp_q.push_back(20'h02000);
    wait_vld();
    check("base_switch_on_vld", FCW, exp_q.pop_front());

    // commit on the same edge as a strobe: old BASE used at that edge
    wait_vld();
    repeat (3) tick();
    write_reg(4'd0, 20'h03000);
    check("commit_vld_old_base", FCW, 20'h02000);
    wait_vld();
    check("commit_vld_new_base", FCW, 20'h03000);

    // random BASE writes at random frame phases
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 6)) tick();
      write_reg(4'd0, 20'($urandom_range(0, 20'hFFFFF)));
      wait_vld();
    end
    stop_run();

    // sweep without repeat
    write_reg(4'd0, 20'h00100);
    write_reg(4'd1, 20'h00010);
    write_reg(4'd2, 20'd3);
    start_run(20'h3);
`ifdef NCO_SWEEP_EN
    exp_q.push_back(20'h00110);
    exp_q.push_back(20'h00120);
    exp_q.push_back(20'h00130);
    for (int i = 0; i < 3; i++) begin
      wait_vld();
      check($sformatf("chirp_fcw_%0d", i), FCW, exp_q.pop_front());
    end
    check("chirp_done", Done, 1);
    check("chirp_en", En, 1);
`endif
    repeat (3) wait_vld();
    stop_run();

    // sweep with repeat and wrap
    write_reg(4'd0, 20'hFFFF0);
    write_reg(4'd1, 20'h00020);
    write_reg(4'd2, 20'd2);
    start_run(20'h7);
`ifdef NCO_SWEEP_EN
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(20'h00010);
      exp_q.push_back(20'h00030);
      exp_q.push_back(20'hFFFF0);
    end
    for (int i = 0; i < 6; i++) begin
      wait_vld();
      check($sformatf("repeat_fcw_%0d", i), FCW, exp_q.pop_front());
      check($sformatf("repeat_done_%0d", i), Done, 0);
    end
`else
    repeat (6) wait_vld();
`endif
    stop_run();

    // random sweeps
    for (int i = 0; i < 6; i++) begin
      write_reg(4'd0, 20'($urandom_range(0, 20'hFFFFF)));
      write_reg(4'd1, 20'($urandom_range(0, 20'hFFFFF)));
      write_reg(4'd2, 20'($urandom_range(0, 4)));
      start_run({17'h0, 1'($urandom_range(0, 1)), 2'b11});
      repeat (10) wait_vld();
      stop_run();
    end

    // reset mid-sweep with an error flagged and a partial frame in flight
    write_reg(4'd0, 20'h00500);
    write_reg(4'd1, 20'h00001);
    write_reg(4'd2, 20'd0);
    start_run(20'h3);
    wait_vld();
    wait_vld();
    send_frame(4'd0, 20'h00777, 23);
    check("midrun_cfgerr", CfgErr, 1);
    CfgEn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      CfgIn = 1'($urandom_range(0, 1));
      tick();
    end
    chk_on = 1'b0;
    rst = 1'b1;
    tick();
    check("midrst_en", En, 0);
    check("midrst_fcw", FCW, 0);
    check("midrst_busy", Busy, 0);
    check("midrst_done", Done, 0);
    check("midrst_cfgerr", CfgErr, 0);
    rst = 1'b0;
    CfgEn = 1'b0;
    CfgIn = 1'b0;
    tick();
    tick();
    check("partial_discard_cfgerr", CfgErr, 0);
    check("partial_discard_busy", Busy, 0);
    m_base = '0; m_step = '0; m_len = 0;

    // registers came back as zero: only STEP is written before the next run
    write_reg(4'd1, 20'h00040);
    start_run(20'h3);
    repeat (4) wait_vld();
    stop_run();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
